multi_bank_rotate_ram: RTL and testbench

//  Generalised ping-pong store: NUM_BANKS banks of DEPTH x WIDTH in one inferred simple-dual-port RAM, rotated as a ring.

---
 rtl/multi_bank_rotate_ram.sv | 147 ++++++++++++++
 tb/tb_multi_bank_rotate_ram.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_bank_rotate_ram.sv
// Ring of NUM_BANKS ping-pong banks in one simple-dual-port RAM with commit/release ownership handshakes.
// Optional macro MULTI_BANK_RAM_OUT_REG_EN adds a read output register (read latency 2 instead of 1).
module multi_bank_rotate_ram #(
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 256,
    parameter int WIDTH     = 512,
    parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int CNT_W     = $clog2(NUM_BANKS + 1),
    parameter     RAM_TYPE  = "block"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    output logic              wr_ready,
    output logic [BANK_W-1:0] wr_bank,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_done,
    output logic              rd_ready,
    output logic [BANK_W-1:0] rd_bank,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic [CNT_W-1:0]  fill_cnt,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int                RAM_WORDS = NUM_BANKS * (2 ** ADDR_W);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_BANKS);

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == LAST_BANK) ? '0 : b + BANK_W'(1);
    endfunction

    logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              commit, release_bank, wr_accept, rd_accept;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              vld1_q;

    (* ram_style = RAM_TYPE *) logic [WIDTH-1:0] mem [0:RAM_WORDS-1];

    assign wr_ready = (fill_cnt_q < FULL_CNT);
    assign rd_ready = (fill_cnt_q != '0);
    assign wr_bank  = wr_ptr_q;
    assign rd_bank  = rd_ptr_q;
    assign fill_cnt = fill_cnt_q;
    assign ovf_err  = ovf_q;
    assign udf_err  = udf_q;
    assign rd_data  = rd_data_q;

    // Flush outranks every strobe, so each acceptance is gated by it here once.
    assign wr_accept    = wr_en   && wr_ready && !flush;
    assign rd_accept    = rd_en   && rd_ready && !flush;
    assign commit       = wr_done && wr_ready && !flush;
    assign release_bank = rd_done && rd_ready && !flush;

    always_comb begin
        wr_ptr_d   = commit       ? next_bank(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = release_bank ? next_bank(rd_ptr_q) : rd_ptr_q;
        fill_cnt_d = fill_cnt_q;
        if (commit && !release_bank) fill_cnt_d = fill_cnt_q + CNT_W'(1);
        if (!commit && release_bank) fill_cnt_d = fill_cnt_q - CNT_W'(1);
        ovf_d = ovf_q | (wr_done && !wr_ready);
        udf_d = udf_q | ((rd_done || rd_en) && !rd_ready);
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_cnt_d = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_cnt_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // NOTE: the storage array has no reset; resetting it would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[{wr_ptr_q, wr_addr}] <= wr_data;
    end

`ifdef MULTI_BANK_RAM_OUT_REG_EN
    logic [WIDTH-1:0] ram_rd_q;
    logic             vld2_q;

    always_ff @(posedge clk) begin
        if (rd_accept) ram_rd_q <= mem[{rd_ptr_q, rd_addr}];
    end

    always_comb begin
        rd_data_d = vld1_q ? ram_rd_q : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            vld1_q    <= rd_accept;
            vld2_q    <= vld1_q;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_valid = vld2_q;
`else
    always_comb begin
        rd_data_d = rd_accept ? mem[{rd_ptr_q, rd_addr}] : rd_data_q;
    end

    // In-flight reads are not cancelled by flush; only reset clears the read pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            vld1_q    <= rd_accept;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_valid = vld1_q;
`endif

endmodule

// File: tb/tb_multi_bank_rotate_ram.sv
// Self-checking bench for multi_bank_rotate_ram (3 banks, 16 x 32): directed scenarios plus random traffic
// compared every cycle against a bank-queue reference model.
module tb_multi_bank_rotate_ram;

    localparam int NB = 3;
    localparam int DP = 16;
    localparam int W  = 32;
`ifdef MULTI_BANK_RAM_OUT_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_ready, rd_ready, rd_valid, ovf_err, udf_err;
    logic [1:0]    wr_bank, rd_bank, fill_cnt;
    logic          wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
    logic [3:0]    wr_addr = '0, rd_addr = '0;
    logic [W-1:0]  wr_data = '0, rd_data;

    multi_bank_rotate_ram #(.NUM_BANKS(NB), .DEPTH(DP), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_ready(wr_ready), .wr_bank(wr_bank), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_done(wr_done),
        .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
        .fill_cnt(fill_cnt), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W-1:0] d;
    } rd_t;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           m_wb, m_rb, m_cnt;
    bit           m_ovf, m_udf, m_valid;
    logic [W-1:0] m_rd_data;
    logic [W-1:0] m_mem [NB][DP];
    rd_t          pend[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wb = 0; m_rb = 0; m_cnt = 0;
        m_ovf = 0; m_udf = 0; m_valid = 0;
        m_rd_data = '0;
        pend.delete();
    endtask

    task automatic compare_all();
        check("wr_ready", 64'(wr_ready), 64'(m_cnt < NB));
        check("rd_ready", 64'(rd_ready), 64'(m_cnt > 0));
        check("wr_bank",  64'(wr_bank),  64'(m_wb));
        check("rd_bank",  64'(rd_bank),  64'(m_rb));
        check("fill_cnt", 64'(fill_cnt), 64'(m_cnt));
        check("ovf_err",  64'(ovf_err),  64'(m_ovf));
        check("udf_err",  64'(udf_err),  64'(m_udf));
        check("rd_valid", 64'(rd_valid), 64'(m_valid));
        check("rd_data",  64'(rd_data),  64'(m_rd_data));
    endtask

    // Apply the current inputs to the model, clock the DUT, then compare and clear the strobes.
    task automatic tick();
        bit w_rdy, r_rdy;
        w_rdy = (m_cnt < NB);
        r_rdy = (m_cnt > 0);
        if (flush) begin
            m_wb = 0; m_rb = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (rd_en && r_rdy) pend.push_back('{due: cyc + L, d: m_mem[m_rb][rd_addr]});
            if ((rd_en || rd_done) && !r_rdy) m_udf = 1;
            if (wr_en && w_rdy) m_mem[m_wb][wr_addr] = wr_data;
            if (wr_done && !w_rdy) m_ovf = 1;
            if (wr_done && w_rdy) begin m_wb = (m_wb + 1) % NB; m_cnt++; end
            if (rd_done && r_rdy) begin m_rb = (m_rb + 1) % NB; m_cnt--; end
        end
        @(posedge clk);
        cyc++;
        #1;
        m_valid = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_valid = 1;
            m_rd_data = pend[0].d;
            void'(pend.pop_front());
        end
        compare_all();
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0; flush = 0;
    endtask

    initial begin
        bit seen;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        compare_all();
        check("t1_reset_wr_bank", 64'(wr_bank), 64'd0);

        // 1: write, commit, read back
        wr_en = 1; wr_addr = 4'd5; wr_data = 32'hA5; tick();
        wr_done = 1; tick();
        check("t1_fill", 64'(fill_cnt), 64'd1);
        check("t1_wr_bank", 64'(wr_bank), 64'd1);
        rd_en = 1; rd_addr = 4'd5; tick();
        for (int i = 1; i < L; i++) tick();
        check("t1_rd_valid", 64'(rd_valid), 64'd1);
        check("t1_rd_data", 64'(rd_data), 64'hA5);
        rd_done = 1; tick();

        // 2: overflow then release with wrap
        flush = 1; tick();
        repeat (3) begin wr_done = 1; tick(); end
        check("t2_fill_full", 64'(fill_cnt), 64'd3);
        check("t2_wr_ready_low", 64'(wr_ready), 64'd0);
        wr_done = 1; tick();
        check("t2_ovf", 64'(ovf_err), 64'd1);
        check("t2_fill_stays", 64'(fill_cnt), 64'd3);
        rd_done = 1; tick();
        check("t2_fill_after_rel", 64'(fill_cnt), 64'd2);
        check("t2_wr_bank_wrap", 64'(wr_bank), 64'd0);

        // 3: simultaneous commit and release
        flush = 1; tick();
        wr_done = 1; tick();
        repeat (7) begin wr_done = 1; rd_done = 1; tick(); end
        check("t3_fill", 64'(fill_cnt), 64'd1);
        check("t3_wr_bank", 64'(wr_bank), 64'd2);
        check("t3_rd_bank", 64'(rd_bank), 64'd1);

        // 4: underflow on release and on read
        flush = 1; tick();
        rd_done = 1; tick();
        check("t4_udf_done", 64'(udf_err), 64'd1);
        check("t4_rd_bank", 64'(rd_bank), 64'd0);
        flush = 1; tick();
        rd_en = 1; rd_addr = 4'd1; tick();
        check("t4_udf_en", 64'(udf_err), 64'd1);
        repeat (L) tick();

        // 5: flush with a read in flight
        flush = 1; tick();
        wr_en = 1; wr_addr = 4'd2; wr_data = 32'h5A5A_0002; tick();
        repeat (2) begin wr_done = 1; tick(); end
        rd_en = 1; rd_addr = 4'd2; tick();
        seen = rd_valid;
        flush = 1; tick();
        seen |= rd_valid;
        check("t5_fill", 64'(fill_cnt), 64'd0);
        check("t5_ptrs", 64'({wr_bank, rd_bank}), 64'd0);
        repeat (L) begin tick(); seen |= rd_valid; end
        check("t5_pending_valid", 64'(seen), 64'd1);
        check("t5_pending_data", 64'(rd_data), 64'h5A5A_0002);

        // Fill every bank so random reads never hit uninitialised words
        flush = 1; tick();
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < DP; a++) begin
                wr_en = 1; wr_addr = 4'(a); wr_data = $urandom; tick();
            end
            wr_done = 1; tick();
        end
        repeat (NB) begin rd_done = 1; tick(); end

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = 4'($urandom_range(0, DP - 1));
            wr_data = $urandom;
            wr_done = ($urandom_range(0, 3) == 0);
            rd_en   = ($urandom_range(0, 1) == 1);
            rd_addr = 4'($urandom_range(0, DP - 1));
            rd_done = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 49) == 0);
            tick();
        end

        // 6: asynchronous reset mid-fill, then rewrite bank 0
        flush = 1; tick();
        repeat (2) begin wr_done = 1; tick(); end
        rd_en = 1; rd_addr = 4'd0; tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t6_async_fill", 64'(fill_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1; wr_addr = 4'd3; wr_data = 32'h1234_5678; tick();
        wr_done = 1; tick();
        rd_en = 1; rd_addr = 4'd3; tick();
        for (int i = 1; i < L; i++) tick();
        check("t6_rd_valid", 64'(rd_valid), 64'd1);
        check("t6_rd_data", 64'(rd_data), 64'h1234_5678);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
